// File: rtl/sim_uart_out_buffer.sv
// sim_uart_out_buffer: batches UART console characters from the DUT and releases them
// to the console printer on newline, FIFO full, or idle timeout.
// Optional macro SIM_UART_CR_STRIP_EN: when defined, input 0x0D bytes are ignored entirely.
module sim_uart_out_buffer #(
    parameter int DEPTH         = 64,
    parameter int FLUSH_TIMEOUT = 1024,
    parameter int DROP_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_ch,
    output logic                    out_valid,
    output logic [7:0]              out_ch,
    input  logic                    out_ready,
    output logic                    line_flush,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;
    // Idle counter only needs to reach FLUSH_TIMEOUT-1; it saturates at all-ones.
    localparam int IW       = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam int TMO_LAST = (FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0;

    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TMO_LAST);
    localparam bit            TMO_EN    = (FLUSH_TIMEOUT != 0);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [IW-1:0]       idle_q, idle_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                ovf_q, ovf_d;
    logic                flush_q, flush_d;
    logic [7:0]          mem_q [DEPTH];

    logic                in_take;
    logic                full;
    logic                push;
    logic                drop;
    logic                pop;
    logic                trigger;

    // Input qualification, push/drop/pop decisions and visible outputs.
    always_comb begin
        in_take = in_valid;
`ifdef SIM_UART_CR_STRIP_EN
        // A stripped CR behaves exactly like an idle cycle.
        in_take = in_valid && (in_ch != 8'h0D);
`endif
        // Fullness is judged before any same-cycle pop, so a write at full is lost.
        full      = (level_q == FULL_LVL);
        push      = in_take && !full;
        drop      = in_take && full;
        out_valid = (state_q == DRAIN) && (level_q != '0);
        pop       = out_valid && out_ready;
        out_ch    = out_valid ? mem_q[rd_ptr_q] : 8'h00;
        line_flush = flush_q;
        overflow   = ovf_q;
        drop_cnt   = drop_q;
        level      = level_q;
    end

    // Next-state logic for pointers, occupancy, idle timer, status and the FILL/DRAIN FSM.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        idle_d   = idle_q;
        flush_d  = 1'b0;
        ovf_d    = ovf_q || drop;
        drop_d   = drop_q;
        trigger  = 1'b0;

        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end

        case (state_q)
            FILL: begin
                if (push || (level_q == '0)) begin
                    idle_d = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + IW'(1);
                end
                trigger = (push && (in_ch == 8'h0A))
                       || (level_d == FULL_LVL)
                       || (TMO_EN && (idle_q == IDLE_LAST) && (level_q != '0));
                if (trigger) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                idle_d = '0;
                // Session ends only once this cycle's push/pop leaves nothing behind.
                if (level_d == '0) begin
                    state_d = FILL;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State register with asynchronous reset; contents are discarded on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idle_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idle_q   <= idle_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            flush_q  <= flush_d;
        end
    end

    // Character storage; no reset needed since validity is tracked by level.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_ch;
        end
    end

endmodule

// File: tb/tb_sim_uart_out_buffer.sv
module tb_sim_uart_out_buffer;

    logic        clock;
    logic        reset;

    // Instance A: DEPTH=8, FLUSH_TIMEOUT=16
    logic        a_valid, a_ready;
    logic [7:0]  a_ch;
    logic        a_out_valid, a_flush, a_ovf;
    logic [7:0]  a_out_ch;
    logic [15:0] a_drop;
    logic [3:0]  a_level;

    // Instance B: DEPTH=64, FLUSH_TIMEOUT=0
    logic        b_valid, b_ready;
    logic [7:0]  b_ch;
    logic        b_out_valid, b_flush, b_ovf;
    logic [7:0]  b_out_ch;
    logic [15:0] b_drop;
    logic [6:0]  b_level;

    int checks;
    int failures;
    logic seen;

    sim_uart_out_buffer #(.DEPTH(8), .FLUSH_TIMEOUT(16), .DROP_W(16)) u_a (
        .clock(clock), .reset(reset),
        .in_valid(a_valid), .in_ch(a_ch),
        .out_valid(a_out_valid), .out_ch(a_out_ch), .out_ready(a_ready),
        .line_flush(a_flush), .overflow(a_ovf), .drop_cnt(a_drop), .level(a_level)
    );

    sim_uart_out_buffer #(.DEPTH(64), .FLUSH_TIMEOUT(0), .DROP_W(16)) u_b (
        .clock(clock), .reset(reset),
        .in_valid(b_valid), .in_ch(b_ch),
        .out_valid(b_out_valid), .out_ch(b_out_ch), .out_ready(b_ready),
        .line_flush(b_flush), .overflow(b_ovf), .drop_cnt(b_drop), .level(b_level)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        a_valid = 0; a_ready = 0; a_ch = 0;
        b_valid = 0; b_ready = 0; b_ch = 0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_ch", a_out_ch, 0);
        check("rst_a_level", a_level, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_a_drop", a_drop, 0);
        check("rst_a_flush", a_flush, 0);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_b_level", b_level, 0);

        // 1: "hi\n" on DEPTH=64 with printer always ready
        b_ready = 1;
        b_valid = 1; b_ch = 8'h68; tick();
        check("t1_fill_no_valid", b_out_valid, 0);
        b_ch = 8'h69; tick();
        b_ch = 8'h0A; tick();
        b_valid = 0;
        check("t1_level3", b_level, 3);
        check("t1_valid0", b_out_valid, 1);
        check("t1_ch0", b_out_ch, 8'h68);
        tick();
        check("t1_ch1", b_out_ch, 8'h69);
        tick();
        check("t1_ch2", b_out_ch, 8'h0A);
        check("t1_no_flush_yet", b_flush, 0);
        tick();
        check("t1_flush", b_flush, 1);
        check("t1_level0", b_level, 0);
        check("t1_valid_off", b_out_valid, 0);
        tick();
        check("t1_flush_once", b_flush, 0);

        // 2: overflow on DEPTH=8 with printer stalled
        a_ready = 0;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1; a_ch = 8'h41 + 8'(i);
            tick();
        end
        a_valid = 0;
        check("t2_level", a_level, 8);
        check("t2_ovf", a_ovf, 1);
        check("t2_drop", a_drop, 2);
        check("t2_valid", a_out_valid, 1);
        a_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("t2_ch", a_out_ch, 32'h41 + i);
            check("t2_no_early_flush", a_flush, 0);
            tick();
        end
        check("t2_flush", a_flush, 1);
        check("t2_level0", a_level, 0);
        check("t2_ovf_sticky", a_ovf, 1);
        tick();
        check("t2_flush_once", a_flush, 0);
        a_ready = 0;

        // 3: idle timeout of 16 cycles
        a_valid = 1; a_ch = 8'h41; tick();
        a_valid = 0;
        seen = 0;
        repeat (15) begin
            tick();
            if (a_out_valid) seen = 1;
        end
        check("t3_not_early", seen, 0);
        tick();
        check("t3_valid_at16", a_out_valid, 1);
        check("t3_ch", a_out_ch, 8'h41);
        a_ready = 1; tick();
        check("t3_flush", a_flush, 1);
        a_ready = 0; tick();

        // 4: asynchronous reset while draining
        a_ready = 0;
        a_valid = 1; a_ch = 8'h31; tick();
        a_ch = 8'h32; tick();
        a_ch = 8'h33; tick();
        a_ch = 8'h34; tick();
        a_ch = 8'h0A; tick();
        a_valid = 0;
        check("t4_level5", a_level, 5);
        check("t4_valid", a_out_valid, 1);
        check("t4_drop_before", a_drop, 2);
        #3 reset = 1'b1;
        #1;
        check("t4_rst_valid", a_out_valid, 0);
        check("t4_rst_level", a_level, 0);
        check("t4_rst_flush", a_flush, 0);
        check("t4_rst_drop", a_drop, 0);
        check("t4_rst_ovf", a_ovf, 0);
        check("t4_rst_ch", a_out_ch, 0);
        #2 reset = 1'b0;
        seen = 0;
        repeat (5) begin
            tick();
            if (a_out_valid || a_flush) seen = 1;
        end
        check("t4_quiet_after", seen, 0);

        // 5: CR handling
        a_ready = 1;
        a_valid = 1; a_ch = 8'h41; tick();
        a_ch = 8'h0D; tick();
        a_ch = 8'h0A; tick();
        a_valid = 0;
        check("t5_ch0", a_out_ch, 8'h41);
        check("t5_drop", a_drop, 0);
`ifdef SIM_UART_CR_STRIP_EN
        check("t5_level", a_level, 2);
        tick();
        check("t5_ch1", a_out_ch, 8'h0A);
`else
        check("t5_level", a_level, 3);
        tick();
        check("t5_ch1", a_out_ch, 8'h0D);
        tick();
        check("t5_ch2", a_out_ch, 8'h0A);
`endif
        tick();
        check("t5_flush", a_flush, 1);
        tick();

        // 6: push and pop together at level 1 in DRAIN
        a_ready = 0;
        a_valid = 1; a_ch = 8'h41; tick();
        a_ch = 8'h0A; tick();
        a_valid = 0;
        check("t6_level2", a_level, 2);
        a_ready = 1; tick();
        check("t6_level1", a_level, 1);
        check("t6_ch_nl", a_out_ch, 8'h0A);
        a_valid = 1; a_ch = 8'h42; tick();
        a_valid = 0;
        check("t6_level_stays", a_level, 1);
        check("t6_still_drain", a_out_valid, 1);
        check("t6_no_flush", a_flush, 0);
        check("t6_ch_b", a_out_ch, 8'h42);
        tick();
        check("t6_flush", a_flush, 1);
        check("t6_level0", a_level, 0);
        a_ready = 0;

        // 3b: timeout disabled keeps a lone character buffered
        b_ready = 1;
        b_valid = 1; b_ch = 8'h41; tick();
        b_valid = 0;
        seen = 0;
        repeat (2000) begin
            tick();
            if (b_out_valid) seen = 1;
        end
        check("t3b_never_valid", seen, 0);
        check("t3b_level1", b_level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_uart_out_buffer.md
Name: sim_uart_out_buffer

Overview:
- Character buffer between SimTop's UART output strobe (io_uart_out_valid / io_uart_out_ch) and the testbench console printer.
- Decouples the DUT's per-cycle character strobes from host printing by batching characters in a FIFO.
- Releases a batch on newline, FIFO full, or idle timeout.
- Keeps sticky overflow status and a dropped-character count so lost console output is visible to the bench.

Parameters:
- DEPTH, 64: FIFO entries. Power of 2, minimum 4.
- FLUSH_TIMEOUT, 1024: idle cycles in FILL with data pending before a forced drain. 0 disables the timeout.
- DROP_W, 16: width of the dropped-character counter.

Ports:
- clock  input  1: simulation clock.
- reset  input  1: asynchronous, active-high reset.
- in_valid  input  1: character strobe from DUT UART out. No backpressure.
- in_ch  input  8: character byte.
- out_valid  output  1: character available to printer.
- out_ch  output  8: head character. Forced to 0 when out_valid=0.
- out_ready  input  1: printer accepts the character this cycle.
- line_flush  output  1: one-cycle pulse when a drain session completes.
- overflow  output  1: sticky. Set on the first dropped character.
- drop_cnt  output  DROP_W: dropped characters, saturating at all-ones.
- level  output  $clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (asynchronous, immediate):
  - state=FILL; FIFO pointers, level, idle_cnt, drop_cnt = 0.
  - overflow=0, line_flush=0, out_valid=0, out_ch=0.
- Push condition: in_valid && !full, where full (level==DEPTH) is evaluated before any same-cycle pop.
  - A write arriving while full is dropped, even if a pop occurs in the same cycle.
  - Each drop sets overflow and increments drop_cnt (saturating).
- Pop condition: out_valid && out_ready.
- out_valid = (state==DRAIN) && level!=0. This is combinational from registered state/level.
- out_ch = mem[rd_ptr] when out_valid.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves level unchanged.
- State FILL:
  - idle_cnt increments each cycle with no accepted push while level!=0; it saturates.
  - idle_cnt clears on an accepted push and whenever level==0.
  - Transition to DRAIN on the next edge when any of the following holds:
    - (a) a pushed character equals 0x0A;
    - (b) level becomes DEPTH after this cycle;
    - (c) FLUSH_TIMEOUT!=0, idle_cnt==FLUSH_TIMEOUT-1 and level!=0.
  - No pops occur in FILL.
- State DRAIN:
  - Pushes continue to be accepted.
  - Stay in DRAIN until the FIFO is empty after the cycle's push/pop. This happens when level==1, a pop occurs and no push occurs.
  - Then go to FILL, clear idle_cnt, and register line_flush=1 for exactly one cycle (the first FILL cycle).
  - A 0x0A pushed during DRAIN does not cause an extra flush pulse; it is drained within the same session.
- Latency: the first character can appear on out_ch at the earliest one cycle after the triggering push edge.
- Characters are never reordered or duplicated.
- overflow and drop_cnt clear only on reset.
- Reset mid-drain: FIFO contents are discarded and out_valid drops immediately. No line_flush is generated.

Optional Feature:
- Macro: SIM_UART_CR_STRIP_EN.
- Defined: an input 0x0D is ignored completely, as if in_valid were 0.
  - It is not stored and not counted as a drop.
  - It does not clear idle_cnt.
  - It is not a drain trigger.
- Undefined: 0x0D is buffered and emitted like any other byte.

Test Plan:
1. DEPTH=64, out_ready=1. Push 0x68, 0x69, 0x0A on consecutive cycles.
   -> DRAIN entered after the 0x0A edge.
   -> out_ch emits 68, 69, 0A on 3 consecutive cycles.
   -> line_flush is high for one cycle after the last pop; level=0.
2. DEPTH=8, out_ready=0. Push 10 bytes 0x41..0x4A.
   -> level=8, overflow=1, drop_cnt=2.
   -> Then raise out_ready: 0x41..0x48 emitted in order, a single line_flush pulse, overflow remains 1.
3. FLUSH_TIMEOUT=16. Push 0x41 once, then idle.
   -> out_valid rises exactly 16 cycles after the push edge, with out_ch=0x41.
   -> With FLUSH_TIMEOUT=0, out_valid stays 0 for 2000 cycles.
4. out_ready=0, DRAIN with level=5. Assert reset mid-cycle.
   -> out_valid, level, line_flush, drop_cnt go to 0 without waiting for a clock edge.
   -> After release, out_valid stays 0 until a new trigger.
5. Push 0x41, 0x0D, 0x0A.
   -> Macro defined: output 41, 0A, drop_cnt=0.
   -> Macro undefined: output 41, 0D, 0A.
6. In DRAIN at level=1, push 0x42 in the same cycle as a pop.
   -> level stays 1, state stays DRAIN, no line_flush.
   -> The next cycle outputs 0x42, followed by the line_flush pulse.
